// File: rtl/am4_useq.sv
`default_nettype none
// ============================================================================
//  Module      : am4_useq
//  Description : Microprogram next-address sequencer. Selects the next
//                microcode address from micro-PC, register/counter, LIFO
//                return stack or direct data, and maintains that state.
//  Revision    : 1.0  initial release
// ============================================================================
module am4_useq #(
   parameter int AW = 12,
   parameter int SD = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic [1:0]    s,
   input  logic          fe_n,
   input  logic          pup,
   input  logic          ctl_n,
   input  logic          cte_n,
   input  logic          ci,
   input  logic [AW-1:0] d,
   output logic [AW-1:0] y,
   output logic          zero,
   output logic          full,
   output logic          empty,
   output logic          sov,
   output logic          sun
);

   // Stack pointer must represent 0..SD inclusive.
   localparam int             SPW  = $clog2(SD + 1);
   localparam logic [SPW-1:0] C_SD = SPW'(SD);

   logic [AW-1:0]  upc_q, upc_d;
   logic [AW-1:0]  rc_q,  rc_d;
   logic [SPW-1:0] sp_q,  sp_d;
   logic [AW-1:0]  stk_q [SD];
   logic [AW-1:0]  stk_d [SD];
   logic           sov_q, sov_d;
   logic           sun_q, sun_d;

   logic [SPW-1:0] w_top_idx;
   logic           w_push;
   logic           w_pop;

   assign w_top_idx = sp_q - SPW'(1);
   assign w_push    = ~fe_n &  pup;
   assign w_pop     = ~fe_n & ~pup;

   assign zero  = (rc_q == '0);
   assign full  = (sp_q == C_SD);
   assign empty = (sp_q == '0);
   assign sov   = sov_q;
   assign sun   = sun_q;

   // Next-address mux; an empty stack reads as address 0.
   always_comb begin
      y = d;
      case (s)
         2'b00:   y = upc_q;
         2'b01:   y = rc_q;
         2'b10:   y = empty ? '0 : stk_q[w_top_idx];
         default: y = d;
      endcase
   end

   // Next-state: PC, stack and counter update independently from pre-edge values.
   always_comb begin
      upc_d = upc_q;
      rc_d  = rc_q;
      sp_d  = sp_q;
      stk_d = stk_q;
      sov_d = sov_q;
      sun_d = sun_q;
      if (ena) begin
         upc_d = y + AW'(ci);
         // The pushed return address is the current micro-PC, not y.
         if (w_push) begin
            if (!full) begin
               stk_d[sp_q] = upc_q;
               sp_d        = sp_q + SPW'(1);
            end else begin
               sov_d = 1'b1;
            end
         end else if (w_pop) begin
            if (!empty) begin
               sp_d = sp_q - SPW'(1);
            end else begin
               sun_d = 1'b1;
            end
         end
         // Load wins over decrement; decrement wraps 0 to all-ones.
         if (!ctl_n) begin
            rc_d = d;
         end else if (!cte_n) begin
            rc_d = rc_q - AW'(1);
         end
      end
   end

   // State registers with asynchronous clear of every entry and sticky flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         upc_q <= '0;
         rc_q  <= '0;
         sp_q  <= '0;
         sov_q <= 1'b0;
         sun_q <= 1'b0;
         for (int i = 0; i < SD; i++) begin
            stk_q[i] <= '0;
         end
      end else begin
         upc_q <= upc_d;
         rc_q  <= rc_d;
         sp_q  <= sp_d;
         sov_q <= sov_d;
         sun_q <= sun_d;
         for (int i = 0; i < SD; i++) begin
            stk_q[i] <= stk_d[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_am4_useq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am4_useq
//  Description : Self-checking bench for am4_useq against a queue-based
//                reference model of the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_am4_useq;
   localparam int AW = 12;
   localparam int SD = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena;
   logic [1:0]    s;
   logic          fe_n, pup, ctl_n, cte_n, ci;
   logic [AW-1:0] d;
   logic [AW-1:0] y;
   logic          zero, full, empty, sov, sun;

   am4_useq #(.AW(AW), .SD(SD)) dut (
      .clk(clk), .rst(rst), .ena(ena), .s(s), .fe_n(fe_n), .pup(pup),
      .ctl_n(ctl_n), .cte_n(cte_n), .ci(ci), .d(d), .y(y), .zero(zero),
      .full(full), .empty(empty), .sov(sov), .sun(sun)
   );

   always #5 clk = ~clk;

   // Reference model state.
   logic [AW-1:0] m_upc, m_rc;
   logic [AW-1:0] m_stk [$];
   logic          m_sov, m_sun;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] m_y();
      case (s)
         2'd0:    return m_upc;
         2'd1:    return m_rc;
         2'd2:    return (m_stk.size() > 0) ? m_stk[$] : '0;
         default: return d;
      endcase
   endfunction

   task automatic m_reset();
      m_upc = '0;
      m_rc  = '0;
      m_stk.delete();
      m_sov = 1'b0;
      m_sun = 1'b0;
   endtask

   task automatic m_edge();
      logic [AW-1:0] yv;
      if (!ena) return;
      yv = m_y();
      if (!fe_n) begin
         if (pup) begin
            if (m_stk.size() < SD) m_stk.push_back(m_upc);
            else                   m_sov = 1'b1;
         end else begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else                  m_sun = 1'b1;
         end
      end
      if (!ctl_n)      m_rc = d;
      else if (!cte_n) m_rc = m_rc - 1'b1;
      m_upc = yv + AW'(ci);
   endtask

   task automatic check_outputs();
      chk("y",     y,     m_y());
      chk("zero",  zero,  m_rc == '0);
      chk("full",  full,  m_stk.size() == SD);
      chk("empty", empty, m_stk.size() == 0);
      chk("sov",   sov,   m_sov);
      chk("sun",   sun,   m_sun);
   endtask

   task automatic idle();
      ena = 1'b1; s = 2'd0; fe_n = 1'b1; pup = 1'b0;
      ctl_n = 1'b1; cte_n = 1'b1; ci = 1'b0; d = '0;
   endtask

   // Entered 1 time unit after a rising edge; leaves 1 unit after the next.
   task automatic cycle();
      #2;
      check_outputs();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   // Mid-cycle reset pulse, fully released before the next edge.
   task automatic async_reset();
      ena = 1'b0;
      #2 rst = 1'b1;
      #1;
      m_reset();
      for (int k = 0; k < 3; k++) begin
         s = 2'(k);
         #1;
         chk("rst_y", y, '0);
         check_outputs();
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      ena = 1'b0;
      rst = 1'b1;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      cycle();
      chk("reset_y", y, 0);

      // Sequential fetch
      idle(); ci = 1'b1;
      repeat (3) cycle();
      chk("fetch_y3", y, 3);
      ci = 1'b0;
      cycle();
      chk("fetch_hold", y, 3);
      ci = 1'b1;
      repeat (2) cycle();

      // Call to 0x100 from upc=5
      idle(); s = 2'd3; d = 12'h100; fe_n = 1'b0; pup = 1'b1; ci = 1'b1;
      #1 chk("call_y", y, 12'h100);
      cycle();
      idle();
      #1 chk("call_empty", empty, 0);
      chk("call_upc", y, 12'h101);

      // Return
      idle(); s = 2'd2; fe_n = 1'b0; pup = 1'b0; ci = 1'b1;
      #1 chk("ret_y", y, 5);
      cycle();
      idle();
      #1 chk("ret_empty", empty, 1);
      chk("ret_upc", y, 6);

      // Counter load, decrement through zero, load priority
      idle(); s = 2'd1; ctl_n = 1'b0; d = 12'd3;
      cycle();
      ctl_n = 1'b1; cte_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 chk("cnt_rc", y, 3 - i);
         chk("cnt_zero", zero, (i == 3));
         cycle();
      end
      #1 chk("cnt_wrap", y, 12'hFFF);
      chk("cnt_wrap_zero", zero, 0);
      ctl_n = 1'b0; cte_n = 1'b0; d = 12'd7;
      cycle();
      idle(); s = 2'd1;
      #1 chk("cnt_prio", y, 7);

      // Stack overflow
      idle(); ci = 1'b1; fe_n = 1'b0; pup = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (i == 4) begin
            #1 chk("full_5th", full, 1);
            chk("sov_5th", sov, 0);
         end
      end
      chk("ovf_sov", sov, 1);
      s = 2'd2;
      #1 chk("ovf_top", y, m_stk[SD-1]);

      // Stack underflow
      idle(); fe_n = 1'b0; pup = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (i == 4) chk("sun_5th", sun, 0);
      end
      #1 chk("unf_sun", sun, 1);
      chk("unf_empty", empty, 1);

      // Enable hold
      idle(); ena = 1'b0; fe_n = 1'b0; pup = 1'b1; ctl_n = 1'b0; d = 12'h055; ci = 1'b1;
      repeat (2) cycle();
      s = 2'd0;
      #1 chk("hold_upc", y, m_upc);
      s = 2'd1;
      #1 chk("hold_rc", y, m_rc);
      chk("hold_empty", empty, 1);

      // Async reset with rc=9, sp=3
      idle(); s = 2'd1; ctl_n = 1'b0; d = 12'd9;
      cycle();
      idle(); fe_n = 1'b0; pup = 1'b1; ci = 1'b1;
      repeat (3) cycle();
      idle(); s = 2'd1;
      #1 chk("pre_rst_rc", y, 9);
      chk("pre_rst_empty", empty, 0);
      async_reset();
      chk("post_rst_sun", sun, 0);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         ena   = ($urandom_range(0, 9) != 0);
         s     = 2'($urandom_range(0, 3));
         fe_n  = ($urandom_range(0, 2) == 0);
         pup   = 1'($urandom_range(0, 1));
         ctl_n = ($urandom_range(0, 5) != 0);
         cte_n = 1'($urandom_range(0, 1));
         ci    = 1'($urandom_range(0, 1));
         d     = AW'($urandom);
         if ($urandom_range(0, 59) == 0) async_reset();
         else                            cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
